// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked ALU with single-cycle logic/arith/compare and bit-serial shifts
module alu_seq_exec #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_sel,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         illegal
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         r_state, w_next;
    logic [3:0]     r_sel;
    logic [SHW-1:0] r_cnt;
    logic [N-1:0]   r_sh, r_result, w_alu, w_step;
    logic           r_zero, r_illegal, w_legal, w_is_shift, w_accept;
    logic [SHW-1:0] w_shamt;

    assign in_ready   = r_state == IDLE;
    assign out_valid  = r_state == DONE;
    assign result     = r_result;
    assign zero       = r_zero;
    assign illegal    = r_illegal;
    assign w_shamt    = op_b[SHW-1:0];
    assign w_accept   = in_valid && r_state == IDLE;
    assign w_is_shift = alu_sel == ALU_SLL || alu_sel == ALU_SRL || alu_sel == ALU_SRA;
    assign w_step     = r_sel == ALU_SLL ? {r_sh[N-2:0], 1'b0}
                                         : {r_sel == ALU_SRA && r_sh[N-1], r_sh[N-1:1]};

    // single-cycle result; shifts yield op_a here, which is the answer when shamt is 0
    always_comb begin
        w_alu   = '0;
        w_legal = 1'b1;
        case (alu_sel)
            ALU_ADD:                   w_alu = op_a + op_b;
            ALU_SUB:                   w_alu = op_a - op_b;
            ALU_SLT:                   w_alu = {{(N-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:                  w_alu = {{(N-1){1'b0}}, op_a < op_b};
            ALU_XOR:                   w_alu = op_a ^ op_b;
            ALU_OR:                    w_alu = op_a | op_b;
            ALU_AND:                   w_alu = op_a & op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu = op_a;
            default:                   w_legal = 1'b0;
        endcase
    end

    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !in_valid ? IDLE : (w_is_shift && w_shamt != '0) ? SHIFT : DONE;
            SHIFT:   w_next = r_cnt == CNT_ONE ? DONE : SHIFT;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // state, operand capture, serial shifting and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel     <= alu_sel;
                r_sh      <= op_a;
                r_cnt     <= w_shamt;
                r_illegal <= !w_legal;
                if (w_next == DONE) begin
                    r_result <= w_alu;
                    r_zero   <= w_alu == '0;
                end
            end
            if (r_state == SHIFT) begin
                r_sh  <= w_step;
                r_cnt <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    r_result <= w_step;
                    r_zero   <= w_step == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and random checks of alu_seq_exec against a behavioural model
module tb_alu_seq_exec;
    localparam int N = 32;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_sel = '0;
    logic [N-1:0]  op_a = '0;
    logic [N-1:0]  op_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  result;
    logic          zero;
    logic          illegal;
    int            n_tests = 0;
    int            n_fail = 0;

    alu_seq_exec #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference behaviour: result, illegal flag and latency from the operation rules
    task automatic model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat);
        int sh;
        sh  = int'(b % 32);
        ill = 1'b0;
        lat = 1;
        case (sel)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  res = a ^ b;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLL:  begin res = a << sh; lat = 1 + sh; end
            ALU_SRL:  begin res = a >> sh; lat = 1 + sh; end
            ALU_SRA:  begin res = 32'($signed(a) >>> sh); lat = 1 + sh; end
            default:  begin res = 32'd0; ill = 1'b1; end
        endcase
    endtask

    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eill;
        int          elat, lat;
        bit          busy_ok;
        model(sel, a, b, er, eill, elat);
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; alu_sel = 4'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < N + 4) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("busy_in_ready", 32'(busy_ok), 32'd1);
        check("result", result, er);
        check("zero", 32'(zero), 32'(er == 0));
        check("illegal", 32'(illegal), 32'(eill));
        check("done_in_ready", 32'(in_ready), 32'd0);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("held_valid", 32'(out_valid), 32'd1);
            check("held_result", result, er);
            check("held_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] rsel;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        do_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0);
        do_op(ALU_SLT, 32'h8000_0000, 32'h1, 0);
        do_op(ALU_SLTU, 32'h8000_0000, 32'h1, 0);
        do_op(ALU_SRA, 32'h8000_0000, 32'd31, 0);
        do_op(ALU_SLL, 32'h1234_5678, 32'h20, 0);
        do_op(ALU_SRL, 32'hF0, 32'd4, 0);
        do_op(ALU_SUB, 32'd5, 32'd7, 10);
        do_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        do_op(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        // reset mid-way through a long shift
        @(negedge clk);
        in_valid = 1'b1; alu_sel = ALU_SLL; op_a = 32'h0000_0ABC; op_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) check("abort_no_result", 32'(out_valid), 32'd0);
        end
        check("abort_idle", 32'(in_ready), 32'd1);
        do_op(ALU_ADD, 32'd2, 32'd3, 0);
        for (int i = 0; i < 60; i++) begin
            rsel = 4'($urandom);
            do_op(rsel, $urandom, (rsel[0] && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                  int'($urandom_range(0, 3)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
